// File: rtl/alu_issue.sv
// ID->EX issue stage for the RV32I pipeline: decodes one instruction into an
// ALU select plus operands and holds it in the ID/EX register under valid/ready flow control.

package alu_issue_pkg;

    typedef enum logic [4:0] {
        ALUNoP     = 5'd0,
        ALUadd     = 5'd1,
        ALUsub     = 5'd2,
        ALUsll     = 5'd3,
        ALUslt     = 5'd4,
        ALUsltu    = 5'd5,
        ALUxor     = 5'd6,
        ALUsrl     = 5'd7,
        ALUsra     = 5'd8,
        ALUor      = 5'd9,
        ALUand     = 5'd10,
        ALUand_inv = 5'd11
    } alu_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_sel_e    sel;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic        br_on_zero;
        logic        illegal;
    } issue_op_t;

endpackage

module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            id_valid,
    output logic            id_ready,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,

    input  logic            flush,

    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [4:0]      ex_alu_sel,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_br_on_zero,
    output logic            ex_illegal,
    output logic            illegal_seen
);

    // ------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    logic [4:0]  shamt;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode   = id_instr[6:0];
    assign rd_field = id_instr[11:7];
    assign funct3   = id_instr[14:12];
    assign shamt    = id_instr[24:20];
    assign funct7   = id_instr[31:25];

    assign imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
    assign imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    assign imm_b = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                    id_instr[30:25], id_instr[11:8], 1'b0};
    assign imm_u = {id_instr[31:12], 12'b0};
    assign imm_j = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                    id_instr[20], id_instr[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    issue_op_t op_d;

    always_comb begin
        // NOTE: the whole bundle gets a zero default first, so every path
        // through the case below leaves each field assigned and no latch forms.
        op_d    = '0;
        op_d.rd = rd_field;

        case (opcode)
            OPC_OP: begin
                op_d.op_a      = id_rs1_data;
                op_d.op_b      = id_rs2_data;
                op_d.reg_write = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: op_d.sel = ALUadd;
                    {F7_ALT,  3'b000}: op_d.sel = ALUsub;
                    {F7_BASE, 3'b001}: op_d.sel = ALUsll;
                    {F7_BASE, 3'b010}: op_d.sel = ALUslt;
                    {F7_BASE, 3'b011}: op_d.sel = ALUsltu;
                    {F7_BASE, 3'b100}: op_d.sel = ALUxor;
                    {F7_BASE, 3'b101}: op_d.sel = ALUsrl;
                    {F7_ALT,  3'b101}: op_d.sel = ALUsra;
                    {F7_BASE, 3'b110}: op_d.sel = ALUor;
                    {F7_BASE, 3'b111}: op_d.sel = ALUand;
                    default:           op_d.illegal = 1'b1;
                endcase
            end

            OPC_OP_IMM: begin
                op_d.op_a      = id_rs1_data;
                op_d.op_b      = imm_i;
                op_d.imm       = imm_i;
                op_d.reg_write = 1'b1;
                case (funct3)
                    3'b000: op_d.sel = ALUadd;
                    3'b010: op_d.sel = ALUslt;
                    3'b011: op_d.sel = ALUsltu;
                    3'b100: op_d.sel = ALUxor;
                    3'b110: op_d.sel = ALUor;
                    3'b111: op_d.sel = ALUand;
                    3'b001: begin
                        op_d.op_b    = {27'b0, shamt};
                        op_d.sel     = ALUsll;
                        op_d.illegal = (funct7 != F7_BASE);
                    end
                    default: begin
                        // funct3 101: srli/srai; funct7 bit 0 set is a 6-bit shamt
                        op_d.op_b = {27'b0, shamt};
                        if (funct7 == F7_BASE) begin
                            op_d.sel = ALUsrl;
                        end else if (funct7 == F7_ALT) begin
                            op_d.sel = ALUsra;
                        end else begin
                            op_d.illegal = 1'b1;
                        end
                    end
                endcase
            end

            OPC_LUI: begin
                op_d.sel       = ALUadd;
                op_d.op_b      = imm_u;
                op_d.imm       = imm_u;
                op_d.reg_write = 1'b1;
            end

            OPC_AUIPC: begin
                op_d.sel       = ALUadd;
                op_d.op_a      = id_pc;
                op_d.op_b      = imm_u;
                op_d.imm       = imm_u;
                op_d.reg_write = 1'b1;
            end

            OPC_JAL, OPC_JALR: begin
                op_d.sel       = ALUadd;
                op_d.op_a      = id_pc;
                op_d.op_b      = 32'd4;
                op_d.imm       = (opcode == OPC_JAL) ? imm_j : imm_i;
                op_d.reg_write = 1'b1;
                op_d.jump      = 1'b1;
            end

            OPC_BRANCH: begin
                op_d.op_a   = id_rs1_data;
                op_d.op_b   = id_rs2_data;
                op_d.imm    = imm_b;
                op_d.branch = 1'b1;
                case (funct3)
                    3'b000: begin op_d.sel = ALUsub;  op_d.br_on_zero = 1'b1; end
                    3'b001: begin op_d.sel = ALUsub;  op_d.br_on_zero = 1'b0; end
                    3'b100: begin op_d.sel = ALUslt;  op_d.br_on_zero = 1'b0; end
                    3'b101: begin op_d.sel = ALUslt;  op_d.br_on_zero = 1'b1; end
                    3'b110: begin op_d.sel = ALUsltu; op_d.br_on_zero = 1'b0; end
                    3'b111: begin op_d.sel = ALUsltu; op_d.br_on_zero = 1'b1; end
                    default: op_d.illegal = 1'b1;
                endcase
            end

            OPC_LOAD: begin
                op_d.sel       = ALUadd;
                op_d.op_a      = id_rs1_data;
                op_d.op_b      = imm_i;
                op_d.imm       = imm_i;
                op_d.reg_write = 1'b1;
                op_d.mem_rd    = 1'b1;
            end

            OPC_STORE: begin
                op_d.sel    = ALUadd;
                op_d.op_a   = id_rs1_data;
                op_d.op_b   = imm_s;
                op_d.imm    = imm_s;
                op_d.mem_wr = 1'b1;
            end

            default: op_d.illegal = 1'b1;
        endcase

        // Illegal ops still flow down the pipe, but as a fully disabled NoP
        if (op_d.illegal) begin
            op_d         = '0;
            op_d.illegal = 1'b1;
        end

        if (rd_field == 5'd0) begin
            op_d.reg_write = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX register and handshake
    // ------------------------------------------------------------------
    issue_op_t       op_q;
    logic [XLEN-1:0] pc_q;
    logic            ex_valid_q;
    logic            ex_valid_d;
    logic            illegal_seen_q;
    logic            illegal_seen_d;
    logic            accept;

    assign id_ready = !ex_valid_q || ex_ready;
    assign accept   = id_valid && id_ready && !flush;

    always_comb begin
        ex_valid_d = ex_valid_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
        illegal_seen_d = illegal_seen_q || (accept && op_d.illegal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q           <= '0;
            pc_q           <= '0;
            ex_valid_q     <= 1'b0;
            illegal_seen_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop here sample
            // pre-edge values, independent of statement order.
            ex_valid_q     <= ex_valid_d;
            illegal_seen_q <= illegal_seen_d;
            if (accept) begin
                op_q <= op_d;
                pc_q <= id_pc;
            end
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_alu_sel    = op_q.sel;
    assign ex_op_a       = op_q.op_a;
    assign ex_op_b       = op_q.op_b;
    assign ex_imm        = op_q.imm;
    assign ex_pc         = pc_q;
    assign ex_rd         = op_q.rd;
    assign ex_reg_write  = op_q.reg_write;
    assign ex_mem_rd     = op_q.mem_rd;
    assign ex_mem_wr     = op_q.mem_wr;
    assign ex_branch     = op_q.branch;
    assign ex_jump       = op_q.jump;
    assign ex_br_on_zero = op_q.br_on_zero;
    assign ex_illegal    = op_q.illegal;
    assign illegal_seen  = illegal_seen_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios, then randomized traffic
// compared against an instruction-level reference model.

module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [4:0]  ex_alu_sel;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_br_on_zero;
    logic        ex_illegal;
    logic        illegal_seen;

    always #5 clk = ~clk;

    alu_issue #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .flush         (flush),
        .ex_ready      (ex_ready),
        .ex_valid      (ex_valid),
        .ex_alu_sel    (ex_alu_sel),
        .ex_op_a       (ex_op_a),
        .ex_op_b       (ex_op_b),
        .ex_imm        (ex_imm),
        .ex_pc         (ex_pc),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_wr     (ex_mem_wr),
        .ex_branch     (ex_branch),
        .ex_jump       (ex_jump),
        .ex_br_on_zero (ex_br_on_zero),
        .ex_illegal    (ex_illegal),
        .illegal_seen  (illegal_seen)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected view of one issued instruction
    typedef struct {
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw, mrd, mwr, br, jmp, boz, ill;
        logic        chk_imm, chk_rd;
    } exp_t;

    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [4:0]  base_tab [8];
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        logic        writes;
        base_tab = '{ALUadd, ALUsll, ALUslt, ALUsltu, ALUxor, ALUsrl, ALUor, ALUand};
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        i_imm = 32'($signed(ins[31:20]));
        s_imm = 32'($signed({ins[31:25], ins[11:7]}));
        b_imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        u_imm = ins & 32'hFFFF_F000;
        j_imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        e = '{sel: ALUNoP, a: 0, b: 0, imm: 0, rd: ins[11:7], rw: 0, mrd: 0, mwr: 0,
              br: 0, jmp: 0, boz: 0, ill: 0, chk_imm: 0, chk_rd: 0};
        writes = 1'b0;
        case (opc)
            7'b0110011: begin
                e.a = r1; e.b = r2; writes = 1'b1;
                if (f7 == 7'h00)                   e.sel = base_tab[f3];
                else if (f7 == 7'h20 && f3 == 0)   e.sel = ALUsub;
                else if (f7 == 7'h20 && f3 == 5)   e.sel = ALUsra;
                else                               e.ill = 1'b1;
            end
            7'b0010011: begin
                e.a = r1; writes = 1'b1;
                if (f3 == 1 || f3 == 5) begin
                    e.b = {27'b0, ins[24:20]};
                    if (f7 == 7'h00)                 e.sel = base_tab[f3];
                    else if (f7 == 7'h20 && f3 == 5) e.sel = ALUsra;
                    else                             e.ill = 1'b1;
                end else begin
                    e.b = i_imm; e.sel = base_tab[f3];
                end
            end
            7'b0110111: begin e.sel = ALUadd; e.b = u_imm; e.imm = u_imm; e.chk_imm = 1; writes = 1; end
            7'b0010111: begin e.sel = ALUadd; e.a = pc; e.b = u_imm; e.imm = u_imm; e.chk_imm = 1; writes = 1; end
            7'b1101111: begin e.sel = ALUadd; e.a = pc; e.b = 4; e.imm = j_imm; e.chk_imm = 1; e.jmp = 1; writes = 1; end
            7'b1100111: begin e.sel = ALUadd; e.a = pc; e.b = 4; e.imm = i_imm; e.chk_imm = 1; e.jmp = 1; writes = 1; end
            7'b1100011: begin
                e.a = r1; e.b = r2; e.imm = b_imm; e.chk_imm = 1; e.br = 1;
                case (f3[2:1])
                    2'b00:   e.sel = ALUsub;
                    2'b10:   e.sel = ALUslt;
                    2'b11:   e.sel = ALUsltu;
                    default: e.ill = 1'b1;
                endcase
                // equal/ge/geu take the branch on a zero ALU result
                e.boz = f3[0] ^ !f3[2];
            end
            7'b0000011: begin e.sel = ALUadd; e.a = r1; e.b = i_imm; e.imm = i_imm; e.chk_imm = 1; e.mrd = 1; writes = 1; end
            7'b0100011: begin e.sel = ALUadd; e.a = r1; e.b = s_imm; e.imm = s_imm; e.chk_imm = 1; e.mwr = 1; end
            default:    e.ill = 1'b1;
        endcase
        e.chk_rd = writes;
        e.rw     = writes && (ins[11:7] != 5'd0);
        if (e.ill) begin
            e.sel = ALUNoP;
            {e.rw, e.mrd, e.mwr, e.br, e.jmp, e.boz} = '0;
            e.chk_imm = 1'b0;
            e.chk_rd  = 1'b0;
        end
        return e;
    endfunction

    // Reference pipeline-register state
    logic        m_valid = 1'b0;
    exp_t        m_op;
    logic [31:0] m_pc   = '0;
    logic        m_seen = 1'b0;

    task automatic check_outputs(input string tag);
        check({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
        check({tag, ".illegal_seen"}, 32'(illegal_seen), 32'(m_seen));
        if (m_valid) begin
            check({tag, ".sel"},     32'(ex_alu_sel),    32'(m_op.sel));
            check({tag, ".illegal"}, 32'(ex_illegal),    32'(m_op.ill));
            check({tag, ".rw"},      32'(ex_reg_write),  32'(m_op.rw));
            check({tag, ".mem_rd"},  32'(ex_mem_rd),     32'(m_op.mrd));
            check({tag, ".mem_wr"},  32'(ex_mem_wr),     32'(m_op.mwr));
            check({tag, ".branch"},  32'(ex_branch),     32'(m_op.br));
            check({tag, ".jump"},    32'(ex_jump),       32'(m_op.jmp));
            check({tag, ".boz"},     32'(ex_br_on_zero), 32'(m_op.boz));
            check({tag, ".pc"},      ex_pc,              m_pc);
            if (!m_op.ill) begin
                check({tag, ".op_a"}, ex_op_a, m_op.a);
                check({tag, ".op_b"}, ex_op_b, m_op.b);
            end
            if (m_op.chk_imm) check({tag, ".imm"}, ex_imm, m_op.imm);
            if (m_op.chk_rd)  check({tag, ".rd"}, 32'(ex_rd), 32'(m_op.rd));
        end
    endtask

    // One clock cycle: entered and left at a falling edge
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                        input logic fl, input logic rdy);
        logic        n_valid;
        exp_t        n_op;
        logic [31:0] n_pc;
        logic        n_seen;
        logic        rdy_exp;
        id_valid = v; id_instr = ins; id_pc = pc; id_rs1_data = r1; id_rs2_data = r2;
        flush = fl; ex_ready = rdy;
        #1;
        rdy_exp = !m_valid || rdy;
        check({tag, ".id_ready"}, 32'(id_ready), 32'(rdy_exp));
        n_valid = m_valid; n_op = m_op; n_pc = m_pc; n_seen = m_seen;
        if (fl) begin
            n_valid = 1'b0;
        end else if (v && rdy_exp) begin
            n_op    = model_decode(ins, pc, r1, r2);
            n_pc    = pc;
            n_valid = 1'b1;
            n_seen  = m_seen || n_op.ill;
        end else if (m_valid && rdy) begin
            n_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_op = n_op; m_pc = n_pc; m_seen = n_seen;
        check_outputs(tag);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opc_tab [9];
        int          k;
        opc_tab = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                    7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011};
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) w[6:0] = opc_tab[k];
        if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
        return w;
    endfunction

    localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] SUB_X3     = 32'h4020_81B3;
    localparam logic [31:0] SRAI_X5_3  = 32'h4033_5293;
    localparam logic [31:0] BGE_8      = 32'h0020_D463;
    localparam logic [31:0] LUI_X0     = 32'h1234_5037;
    localparam logic [31:0] ADDI_X7_42 = 32'h02A0_0393;
    localparam logic [31:0] ADD_X4     = 32'h0020_8233;

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_instr = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0;
        flush = 0; ex_ready = 0;
        m_op = model_decode(32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Reset state
        check("rst.ex_valid", 32'(ex_valid), 32'd0);
        check("rst.sel", 32'(ex_alu_sel), 32'(ALUNoP));
        check("rst.op_a", ex_op_a, 32'd0);
        check("rst.op_b", ex_op_b, 32'd0);
        check("rst.imm", ex_imm, 32'd0);
        check("rst.pc", ex_pc, 32'd0);
        check("rst.rd", 32'(ex_rd), 32'd0);
        check("rst.flags", 32'({ex_reg_write, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump,
                                ex_br_on_zero, ex_illegal}), 32'd0);
        check("rst.illegal_seen", 32'(illegal_seen), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.id_ready", 32'(id_ready), 32'd1);

        // Directed decode cases
        step("addi", 1, ADDI_X1_5, 32'h100, 32'd0, 32'd0, 0, 1);
        check("addi.sel", 32'(ex_alu_sel), 32'(ALUadd));
        check("addi.b", ex_op_b, 32'd5);
        check("addi.rd", 32'(ex_rd), 32'd1);
        check("addi.rw", 32'(ex_reg_write), 32'd1);

        step("sub", 1, SUB_X3, 32'h104, 32'd7, 32'd9, 0, 1);
        check("sub.sel", 32'(ex_alu_sel), 32'(ALUsub));
        check("sub.a", ex_op_a, 32'd7);
        check("sub.b", ex_op_b, 32'd9);
        check("sub.rd", 32'(ex_rd), 32'd3);

        step("srai", 1, SRAI_X5_3, 32'h108, 32'hF000_0000, 32'd1, 0, 1);
        check("srai.sel", 32'(ex_alu_sel), 32'(ALUsra));
        check("srai.b", ex_op_b, 32'd3);

        step("bge", 1, BGE_8, 32'h10C, 32'd1, 32'd2, 0, 1);
        check("bge.sel", 32'(ex_alu_sel), 32'(ALUslt));
        check("bge.boz", 32'(ex_br_on_zero), 32'd1);
        check("bge.imm", ex_imm, 32'd8);
        check("bge.rw", 32'(ex_reg_write), 32'd0);

        step("lui", 1, LUI_X0, 32'h110, 32'd3, 32'd4, 0, 1);
        check("lui.sel", 32'(ex_alu_sel), 32'(ALUadd));
        check("lui.b", ex_op_b, 32'h1234_5000);
        check("lui.rw", 32'(ex_reg_write), 32'd0);

        // Backpressure: lui held while EX stalls
        for (int i = 0; i < 3; i++) begin
            step("stall", 1, ADDI_X7_42, 32'h114, 32'd0, 32'd0, 0, 0);
            check("stall.b_frozen", ex_op_b, 32'h1234_5000);
        end
        step("release", 1, ADDI_X7_42, 32'h114, 32'd0, 32'd0, 0, 1);
        check("release.b", ex_op_b, 32'd42);

        // Flush with a stalled op and an ID op presented
        step("pre_flush", 1, ADD_X4, 32'h118, 32'd5, 32'd6, 0, 0);
        step("flush", 1, ADD_X4, 32'h118, 32'd5, 32'd6, 1, 0);
        check("flush.ex_valid", 32'(ex_valid), 32'd0);
        step("post_flush", 0, ADD_X4, 32'h11C, 32'd0, 32'd0, 0, 1);

        // Illegal op, sticky flag, then async reset mid-stall
        step("illegal", 1, 32'hFFFF_FFFF, 32'h120, 32'd1, 32'd2, 0, 1);
        check("illegal.sel", 32'(ex_alu_sel), 32'(ALUNoP));
        check("illegal.flag", 32'(ex_illegal), 32'd1);
        check("illegal.seen", 32'(illegal_seen), 32'd1);
        step("sticky", 1, ADDI_X1_5, 32'h124, 32'd0, 32'd0, 0, 1);
        check("sticky.seen", 32'(illegal_seen), 32'd1);
        step("hold", 1, ADD_X4, 32'h128, 32'd0, 32'd0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid.ex_valid", 32'(ex_valid), 32'd0);
        check("rst_mid.seen", 32'(illegal_seen), 32'd0);
        m_valid = 1'b0; m_seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
                 $urandom, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

ID→EX issue stage for the RV32I pipeline: decodes a valid instruction from ID into an ALU function select (`ALUSel` encodings from `Riscv_defs.svh`) plus operand A/B, and registers them in the ID/EX pipeline register. It is the producer side of the ALU's `a`/`b`/`ALUSel` interface. It handles valid/ready backpressure from EX and flushes on redirect.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  ID holds an instruction.
- `id_ready`  out  1  issue stage accepts this cycle.
- `id_instr`  in  32  instruction word.
- `id_pc`  in  32  PC of `id_instr`.
- `id_rs1_data`, `id_rs2_data`  in  32  register file (forwarded) read data.
- `flush`  in  1  branch/jump redirect; kill the ID/EX contents.
- `ex_ready`  in  1  EX consumes the registered op this cycle.
- `ex_valid`  out  1  ID/EX register holds an op.
- `ex_alu_sel`  out  5  `ALUSel` for the ALU.
- `ex_op_a`, `ex_op_b`  out  32  ALU `a`, `b`.
- `ex_imm`  out  32  sign-extended immediate, used for branch/JAL targets.
- `ex_pc`  out  32  registered PC.
- `ex_rd`  out  5  destination register.
- `ex_reg_write`  out  1  writeback enable; forced to 0 when rd=0.
- `ex_mem_rd`, `ex_mem_wr`, `ex_branch`, `ex_jump`  out  1 each  class flags.
- `ex_br_on_zero`  out  1  the branch is taken when `zero_flag`=1; otherwise it is taken when `zero_flag`=0.
- `ex_illegal`  out  1  unsupported encoding.
- `illegal_seen`  out  1  sticky: set by any issued illegal op, cleared only by reset.

## Operation
- Decode is combinational from `id_instr`. Result is loaded into the register on `id_valid && id_ready && !flush`.
- OP (0110011): funct3/funct7[5] → add/sub/sll/slt/sltu/xor/srl/sra/or/and. A=rs1, B=rs2. Other funct7 → illegal.
- OP-IMM (0010011): addi/slti/sltiu/xori/ori/andi use B=I-imm. Shifts use B={27'b0,shamt}.
  - slli/srli/srai map to `ALUsll`/`ALUsrl`/`ALUsra`. The 6-bit shift variants are never issued.
  - Bad funct7 on a shift → illegal.
- LUI: `ALUadd`, A=0, B=U-imm.
- AUIPC: `ALUadd`, A=pc, B=U-imm.
- JAL/JALR: `ALUadd`, A=pc, B=4 (link value); `ex_jump`=1. `ex_imm`=J-imm or I-imm.
- BRANCH: A=rs1, B=rs2, `ex_reg_write`=0.
  - beq: `ALUsub`, `ex_br_on_zero`=1.
  - bne: `ALUsub`, `ex_br_on_zero`=0.
  - blt: `ALUslt`, `ex_br_on_zero`=0.
  - bge: `ALUslt`, `ex_br_on_zero`=1.
  - bltu: `ALUsltu`, `ex_br_on_zero`=0.
  - bgeu: `ALUsltu`, `ex_br_on_zero`=1.
  - funct3 010/011 → illegal.
- LOAD/STORE: `ALUadd`, A=rs1, B=I-imm (load) or S-imm (store). Loads set `ex_mem_rd`, stores set `ex_mem_wr`; stores have `ex_reg_write`=0.
- Any other opcode → illegal.
- An illegal op is still issued: `ex_alu_sel`=`ALUNoP`, `ex_illegal`=1, and all enables are 0.
- `ALUand_inv` is never issued.

## Timing
- Latency: 1 cycle from ID acceptance to `ex_valid`.
- `id_ready` = `!ex_valid || ex_ready`. It is combinational and does not depend on `id_valid`.
- Register update on each rising edge, first matching rule wins:
  - `flush` → `ex_valid`←0, regardless of `ex_ready` or an ID handshake. Other fields may keep stale values.
  - `id_valid && id_ready` → load the new op; `ex_valid`←1.
  - `ex_valid && ex_ready` (no new op) → `ex_valid`←0.
  - otherwise → hold all outputs stable.
- Simultaneous consume and accept: back-to-back issue with no bubble, so full throughput is 1 op/cycle.
- While `ex_valid && !ex_ready`, outputs are frozen bit-exact.
- Reset: every output is 0 (`ex_alu_sel`=`ALUNoP`, `illegal_seen`=0), and `id_ready`=1 once reset is released.
  - Reset asserted mid-stall drops the pending op immediately (async).
- `illegal_seen` sets on the edge that loads an illegal op.

## Test plan
- **Reset:** `rst_n`=0 → all outputs 0; release, `id_valid`=1 with `id_instr`=0x00500093 (addi x1,x0,5), rs1_data=0 → next cycle `ex_valid`=1, sel=`ALUadd`, A=0, B=5, rd=1, `ex_reg_write`=1.
- **R-type and shift-immediate:** 0x402081B3 (sub x3,x1,x2), rs1=7, rs2=9 → `ALUsub`, A=7, B=9, rd=3. Then 0x40335293 (srai x5,x6,3) → `ALUsra`, B=3.
- **Branch/upper-immediate:** 0x0020D463 (bge x1,x2,8) → `ALUslt`, `ex_br_on_zero`=1, `ex_imm`=8, `ex_reg_write`=0. Then 0x12345037 (lui x0) → `ALUadd`, B=0x12345000, `ex_reg_write`=0.
- **Backpressure:** hold `ex_ready`=0 for 3 cycles with `id_valid`=1 → `id_ready`=0 and outputs unchanged. On `ex_ready`=1 the next op loads in the same edge.
- **Flush:** `flush`=1 while `id_valid`=1 and a stalled op is present → next cycle `ex_valid`=0 and the ID op is not taken.
- **Illegal/reset mid-op:** `id_instr`=0xFFFFFFFF → `ALUNoP`, `ex_illegal`=1, `illegal_seen`=1 and sticky. Then pulse `rst_n` low mid-stall → `ex_valid` and `illegal_seen` clear immediately.
